// File: rtl/qc_pkg.sv
// Shared constants for the queue calculator controller: opcodes, queue ops,
// error codes and the sequencer state encoding.
package qc_pkg;

  localparam logic [3:0] OP_PUSH = 4'b0000;
  localparam logic [3:0] OP_POP  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MULL = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_REM  = 4'b0110;

  localparam logic [1:0] Q_PUSH         = 2'b00;
  localparam logic [1:0] Q_SLEEP        = 2'b01;
  localparam logic [1:0] Q_POP          = 2'b11;
  localparam logic [1:0] Q_GET_AND_PUSH = 2'b10;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
  localparam logic [2:0] ERR_CALC      = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL   = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // Only the divide family may legitimately raise the ALU error flag.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/queue_calc_ctrl_if.sv
// Instruction handshake and popped-value output of the queue calculator.
interface queue_calc_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_push_val;
  logic       out_valid;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_opcode, in_push_val,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_opcode, in_push_val,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/qc_circ_queue.sv
// Circular operand queue: storage, head/tail/count and the two oldest entries
// presented as peek0 (head) and peek1 (head+1), zero when absent.
module qc_circ_queue #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop1,
  input  logic          pop2_push,
  input  logic [7:0]    wdata,
  output logic [7:0]    peek0,
  output logic [7:0]    peek1,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW-1:0] head_p1;

  assign head_p1 = head + AW'(1);
  assign peek0   = (count != '0)           ? mem[head]    : 8'h00;
  assign peek1   = (count > (AW+1)'(1))    ? mem[head_p1] : 8'h00;

  // When full, tail == head, so get-and-push overwrites a slot being consumed.
  always_ff @(posedge clk) begin
    if (push || pop2_push) mem[tail] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (push) begin
      tail  <= tail + AW'(1);
      count <= count + (AW+1)'(1);
    end else if (pop1) begin
      head  <= head + AW'(1);
      count <= count - (AW+1)'(1);
    end else if (pop2_push) begin
      head  <= head + AW'(2);
      tail  <= tail + AW'(1);
      count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/queue_calc_ctrl.sv
// Sequencer for the queue calculator ALU: IDLE -> EXEC -> COMMIT, with sticky
// error capture. Optional counters under QUEUE_CALC_CTRL_STATS_EN.
module queue_calc_ctrl
  import qc_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  queue_calc_ctrl_if.slave bus,
  output logic [3:0]    alu_opcode,
  output logic [7:0]    alu_push_val,
  output logic [15:0]   alu_operands,
  input  logic [7:0]    alu_result,
  input  logic [1:0]    alu_queue_op,
  input  logic          alu_calc_err,
  output logic [AW:0]   q_count,
  output logic          busy,
  output logic          err,
  output logic [2:0]    err_code,
  input  logic          clr_err
`ifdef QUEUE_CALC_CTRL_STATS_EN
  ,
  output logic [15:0]   stat_instr,
  output logic [15:0]   stat_err
`endif
);

  state_t     state, state_n;
  logic [7:0] res_q;
  logic [1:0] qop_q;
  logic [2:0] chk_code;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic [7:0] peek0, peek1;
  logic       q_push, q_pop1, q_pop2_push;

  qc_circ_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .pop1      (q_pop1),
    .pop2_push (q_pop2_push),
    .wdata     (res_q),
    .peek0     (peek0),
    .peek1     (peek1),
    .count     (q_count)
  );

  assign alu_operands  = {peek1, peek0};
  assign bus.in_ready  = rst && (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state == EXEC) || (state == COMMIT);

  assign q_push      = (state == COMMIT) && (qop_q == Q_PUSH);
  assign q_pop1      = (state == COMMIT) && (qop_q == Q_POP);
  assign q_pop2_push = (state == COMMIT) && (qop_q == Q_GET_AND_PUSH);

  // Checks in priority order; first hit wins.
  always_comb begin
    chk_code = ERR_NONE;
    if (alu_calc_err && !is_div_op(alu_opcode))
      chk_code = ERR_ILLEGAL;
    else if ((alu_queue_op == Q_POP && q_count == '0) ||
             (alu_queue_op == Q_GET_AND_PUSH && q_count < (AW+1)'(2)))
      chk_code = ERR_UNDERFLOW;
    else if (alu_calc_err)
      chk_code = ERR_CALC;
    else if (alu_queue_op == Q_PUSH && q_count == (AW+1)'(DEPTH))
      chk_code = ERR_OVERFLOW;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid) state_n = EXEC;
      EXEC:    state_n = (chk_code != ERR_NONE) ? ERROR : COMMIT;
      COMMIT:  state_n = IDLE;
      ERROR:   if (clr_err) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_opcode   <= '0;
      alu_push_val <= '0;
      res_q        <= '0;
      qop_q        <= '0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          alu_opcode   <= bus.in_opcode;
          alu_push_val <= bus.in_push_val;
        end
        EXEC: begin
          res_q <= alu_result;
          qop_q <= alu_queue_op;
          if (chk_code != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= chk_code;
          end
        end
        COMMIT: if (qop_q == Q_POP) begin
          out_valid_q <= 1'b1;
          out_data_q  <= peek0;
        end
        ERROR: if (clr_err) begin
          err      <= 1'b0;
          err_code <= ERR_NONE;
        end
        default: ;
      endcase
    end
  end

`ifdef QUEUE_CALC_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_instr <= '0;
      stat_err   <= '0;
    end else begin
      if (state == COMMIT && stat_instr != 16'hFFFF)
        stat_instr <= stat_instr + 16'd1;
      if (state == EXEC && chk_code != ERR_NONE && stat_err != 16'hFFFF)
        stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_calc_ctrl.sv
// Directed bench for queue_calc_ctrl with a behavioural ALU and a scoreboard
// of expected popped values.
module tb_queue_calc_ctrl;
  import qc_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  queue_calc_ctrl_if bus();

  logic [3:0]  alu_opcode;
  logic [7:0]  alu_push_val;
  logic [15:0] alu_operands;
  logic [7:0]  alu_result;
  logic [1:0]  alu_queue_op;
  logic        alu_calc_err;
  logic [AW:0] q_count;
  logic        busy, err, clr_err;
  logic [2:0]  err_code;
`ifdef QUEUE_CALC_CTRL_STATS_EN
  logic [15:0] stat_instr, stat_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  queue_calc_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_opcode   (alu_opcode),
    .alu_push_val (alu_push_val),
    .alu_operands (alu_operands),
    .alu_result   (alu_result),
    .alu_queue_op (alu_queue_op),
    .alu_calc_err (alu_calc_err),
    .q_count      (q_count),
    .busy         (busy),
    .err          (err),
    .err_code     (err_code),
    .clr_err      (clr_err)
`ifdef QUEUE_CALC_CTRL_STATS_EN
    ,
    .stat_instr   (stat_instr),
    .stat_err     (stat_err)
`endif
  );

  // Behavioural ALU: a = head, b = head+1.
  logic [7:0] a_op, b_op;
  assign a_op = alu_operands[7:0];
  assign b_op = alu_operands[15:8];

  always_comb begin
    alu_result   = 8'h00;
    alu_queue_op = Q_SLEEP;
    alu_calc_err = 1'b0;
    case (alu_opcode)
      OP_PUSH: begin alu_result = alu_push_val; alu_queue_op = Q_PUSH; end
      OP_POP:  alu_queue_op = Q_POP;
      OP_ADD:  begin alu_result = a_op + b_op; alu_queue_op = Q_GET_AND_PUSH; end
      OP_SUB:  begin alu_result = b_op - a_op; alu_queue_op = Q_GET_AND_PUSH; end
      OP_MULL: begin alu_result = 8'(a_op * b_op); alu_queue_op = Q_GET_AND_PUSH; end
      OP_DIV: begin
        alu_queue_op = Q_GET_AND_PUSH;
        if (b_op == 8'h00) alu_calc_err = 1'b1;
        else alu_result = a_op / b_op;
      end
      OP_REM: begin
        alu_queue_op = Q_GET_AND_PUSH;
        if (b_op == 8'h00) alu_calc_err = 1'b1;
        else alu_result = a_op % b_op;
      end
      4'b0111: alu_calc_err = 1'b1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      chk("pop_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("pop_data", 32'(bus.out_data), 32'(sb.pop_front()));
    end
  end

  // Issue one instruction; returns at the negedge after its COMMIT edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = op;
    bus.in_push_val = v;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_expect(input logic [7:0] v);
    sb.push_back(v);
    issue(OP_POP, 8'h00);
  endtask

  task automatic clear_err();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_code", 32'(err_code), 32'd0);
    chk("clr_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_push_val = '0; clr_err = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outv", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // 3 - 5 wraps to 254
    issue(OP_PUSH, 8'd5);
    issue(OP_PUSH, 8'd3);
    issue(OP_SUB, 8'd0);
    chk("sub_count", 32'(q_count), 32'd1);
    chk("sub_operands", 32'(alu_operands), 32'h00FE);
    pop_expect(8'd254);
    chk("sub_pop_count", 32'(q_count), 32'd0);

    issue(OP_PUSH, 8'd7);
    issue(OP_PUSH, 8'd2);
    issue(OP_MULL, 8'd0);
    pop_expect(8'd14);
    chk("mull_count", 32'(q_count), 32'd0);

    // divide by zero leaves the queue untouched
    issue(OP_PUSH, 8'd9);
    issue(OP_PUSH, 8'd0);
    issue(OP_DIV, 8'd0);
    chk("div0_err", 32'(err), 32'd1);
    chk("div0_code", 32'(err_code), 32'(ERR_CALC));
    chk("div0_count", 32'(q_count), 32'd2);
    chk("div0_ready", 32'(bus.in_ready), 32'd0);
    chk("div0_operands", 32'(alu_operands), 32'h0009);
    clear_err();
    pop_expect(8'd9);
    pop_expect(8'd0);

    issue(OP_POP, 8'd0);
    chk("uf_pop_code", 32'(err_code), 32'(ERR_UNDERFLOW));
    clear_err();
    issue(OP_PUSH, 8'd4);
    issue(OP_ADD, 8'd0);
    chk("uf_add_code", 32'(err_code), 32'(ERR_UNDERFLOW));
    chk("uf_add_count", 32'(q_count), 32'd1);
    clear_err();
    pop_expect(8'd4);

    // fill, overflow, then get-and-push on the full queue
    for (int i = 0; i < DEPTH; i++) issue(OP_PUSH, 8'(10 + i));
    chk("full_count", 32'(q_count), 32'(DEPTH));
    chk("full_operands", 32'(alu_operands), 32'h0B0A);
    issue(OP_PUSH, 8'd99);
    chk("of_code", 32'(err_code), 32'(ERR_OVERFLOW));
    chk("of_count", 32'(q_count), 32'(DEPTH));
    clear_err();
    issue(OP_ADD, 8'd0);
    chk("full_add_err", 32'(err), 32'd0);
    chk("full_add_count", 32'(q_count), 32'(DEPTH - 1));
    chk("full_add_operands", 32'(alu_operands), 32'h0D0C);
    for (int i = 2; i < DEPTH; i++) pop_expect(8'(10 + i));
    pop_expect(8'd21);
    chk("drain_count", 32'(q_count), 32'd0);

    issue(4'b0111, 8'd0);
    chk("illegal_code", 32'(err_code), 32'(ERR_ILLEGAL));
    clear_err();
    issue(OP_PUSH, 8'd1);
    issue(4'b1010, 8'd0);
    chk("sleep_err", 32'(err), 32'd0);
    chk("sleep_count", 32'(q_count), 32'd1);
    chk("sleep_operands", 32'(alu_operands), 32'h0001);

    // reset while an instruction is in EXEC
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_opcode = OP_PUSH; bus.in_push_val = 8'd50;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_count", 32'(q_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("midrst_count_hold", 32'(q_count), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
